// File: rtl/exp_request_ctrl.sv
// Requester side of the CP0 exception interface: synchronises raw interrupt
// lines, latches edge events (or follows levels), applies the global and
// per-source block bits, and presents one prioritised one-hot request at a time.
//
// state   | meaning
// IDLE    | no request outstanding; waiting for an eligible pending source
// REQ     | ExpSrc driven for the latched cause; waiting for has_exp
// SERVICE | handler running; ExpSrc low until is_eret
module exp_request_ctrl #(
  parameter int                NSRC      = 3,
  parameter logic [NSRC-1:0]   EDGE_MASK = {NSRC{1'b1}},
  parameter int                CAUSE_W   = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NSRC-1:0]    irq_in,
  input  logic               exp_block,
  input  logic [NSRC-1:0]    src_mask,
  input  logic               has_exp,
  input  logic               is_eret,
  output logic [NSRC-1:0]    ExpSrc,
  output logic [CAUSE_W-1:0] cause,
  output logic               in_service,
  output logic [NSRC-1:0]    pending,
  output logic [NSRC-1:0]    overrun
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [NSRC-1:0] ONE = NSRC'(1);

  state_t             state, state_nxt;
  logic [CAUSE_W-1:0] cause_nxt;
  logic [NSRC-1:0]    sync1, sync2, sync3;
  logic [NSRC-1:0]    edge_set, ack_clr, elig, cause_hot;
  logic [NSRC-1:0]    pending_nxt, overrun_nxt;
  logic [CAUSE_W-1:0] win_idx;
  logic               win_any;

  // Two-flop synchroniser plus a third flop for rising-edge detection
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign cause_hot = ONE << cause;
  assign edge_set  = sync2 & ~sync3 & EDGE_MASK;
  // Acceptance clears only the winner, and only for edge sources
  assign ack_clr   = (state == REQ && has_exp) ? (cause_hot & EDGE_MASK) : '0;

  // Pending/overrun update: a same-cycle set beats the acceptance clear and
  // is not counted as an overrun, since the old event is being consumed
  always_comb begin
    pending_nxt = (((pending & ~ack_clr) | edge_set) & EDGE_MASK) | (sync2 & ~EDGE_MASK);
    overrun_nxt = overrun | (edge_set & pending & ~ack_clr);
  end

  // Pending and sticky overrun registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= pending_nxt;
      overrun <= overrun_nxt;
    end
  end

  assign elig = exp_block ? '0 : (pending & ~src_mask);

  // Fixed priority: lowest eligible index wins
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_idx = CAUSE_W'(i);
        win_any = 1'b1;
      end
    end
  end

  // State and cause registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cause <= '0;
    end else begin
      state <= state_nxt;
      cause <= cause_nxt;
    end
  end

  // Next-state logic; cause is only re-latched on IDLE->REQ
  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    case (state)
      IDLE: begin
        if (win_any) begin
          cause_nxt = win_idx;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (has_exp)
          state_nxt = SERVICE;
        else if ((elig & cause_hot) == '0)
          state_nxt = IDLE;
      end
      SERVICE: begin
        if (is_eret)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request is decoded straight from state so reset drops it immediately
  assign ExpSrc     = (state == REQ) ? cause_hot : '0;
  assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_exp_request_ctrl.sv
// Directed bench for exp_request_ctrl: default all-edge instance plus a
// second instance with source 0 level-sensitive.
module tb_exp_request_ctrl;

  logic       clk, clr;
  logic [2:0] irq_in, src_mask;
  logic       exp_block, has_exp, is_eret;
  logic [2:0] ExpSrc, pending, overrun;
  logic [1:0] cause;
  logic       in_service;

  logic [2:0] irq2;
  logic       has_exp2, is_eret2;
  logic [2:0] ExpSrc2, pending2, overrun2;
  logic [1:0] cause2;
  logic       in_service2;

  int checks = 0;
  int failures = 0;

  exp_request_ctrl dut (
    .clk(clk), .clr(clr), .irq_in(irq_in), .exp_block(exp_block),
    .src_mask(src_mask), .has_exp(has_exp), .is_eret(is_eret),
    .ExpSrc(ExpSrc), .cause(cause), .in_service(in_service),
    .pending(pending), .overrun(overrun)
  );

  exp_request_ctrl #(.NSRC(3), .EDGE_MASK(3'b110), .CAUSE_W(2)) dut_lvl (
    .clk(clk), .clr(clr), .irq_in(irq2), .exp_block(exp_block),
    .src_mask(src_mask), .has_exp(has_exp2), .is_eret(is_eret2),
    .ExpSrc(ExpSrc2), .cause(cause2), .in_service(in_service2),
    .pending(pending2), .overrun(overrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr = 1'b0; irq_in = '0; irq2 = '0; src_mask = '0; exp_block = 1'b0;
    has_exp = 1'b0; is_eret = 1'b0; has_exp2 = 1'b0; is_eret2 = 1'b0;
    #1 clr = 1'b1;
    step(2);
    clr = 1'b0;
    step(1);
    checks++; if (ExpSrc !== 3'b000) begin failures++; $display("FAIL reset_expsrc got=%b exp=000", ExpSrc); end
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL reset_pending got=%b exp=000", pending); end
    checks++; if (overrun !== 3'b000) begin failures++; $display("FAIL reset_overrun got=%b exp=000", overrun); end
    checks++; if (cause !== 2'd0) begin failures++; $display("FAIL reset_cause got=%0d exp=0", cause); end
    checks++; if (in_service !== 1'b0) begin failures++; $display("FAIL reset_in_service got=%b exp=0", in_service); end
  endtask

  task automatic test_single_pulse;
    irq_in = 3'b010;
    step(1);
    irq_in = 3'b000;
    step(2);
    checks++; if (pending !== 3'b010) begin failures++; $display("FAIL t1_pending_set got=%b exp=010", pending); end
    checks++; if (ExpSrc !== 3'b000) begin failures++; $display("FAIL t1_no_req_yet got=%b exp=000", ExpSrc); end
    step(1);
    checks++; if (ExpSrc !== 3'b010) begin failures++; $display("FAIL t1_req got=%b exp=010", ExpSrc); end
    checks++; if (cause !== 2'd1) begin failures++; $display("FAIL t1_cause got=%0d exp=1", cause); end
    has_exp = 1'b1;
    step(1);
    has_exp = 1'b0;
    checks++; if (ExpSrc !== 3'b000) begin failures++; $display("FAIL t1_ack_expsrc got=%b exp=000", ExpSrc); end
    checks++; if (in_service !== 1'b1) begin failures++; $display("FAIL t1_in_service got=%b exp=1", in_service); end
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL t1_ack_pending got=%b exp=000", pending); end
    checks++; if (cause !== 2'd1) begin failures++; $display("FAIL t1_cause_held got=%0d exp=1", cause); end
    step(2);
    checks++; if (in_service !== 1'b1) begin failures++; $display("FAIL t1_service_held got=%b exp=1", in_service); end
    is_eret = 1'b1;
    step(1);
    is_eret = 1'b0;
    checks++; if (in_service !== 1'b0) begin failures++; $display("FAIL t1_eret got=%b exp=0", in_service); end
    step(2);
    checks++; if (ExpSrc !== 3'b000) begin failures++; $display("FAIL t1_idle got=%b exp=000", ExpSrc); end
    checks++; if (overrun !== 3'b000) begin failures++; $display("FAIL t1_overrun got=%b exp=000", overrun); end
  endtask

  task automatic test_priority;
    irq_in = 3'b101;
    step(1);
    irq_in = 3'b000;
    step(3);
    checks++; if (ExpSrc !== 3'b001) begin failures++; $display("FAIL t2_req0 got=%b exp=001", ExpSrc); end
    checks++; if (cause !== 2'd0) begin failures++; $display("FAIL t2_cause0 got=%0d exp=0", cause); end
    has_exp = 1'b1;
    step(1);
    has_exp = 1'b0;
    checks++; if (pending !== 3'b100) begin failures++; $display("FAIL t2_pending got=%b exp=100", pending); end
    is_eret = 1'b1;
    step(1);
    is_eret = 1'b0;
    step(1);
    checks++; if (ExpSrc !== 3'b100) begin failures++; $display("FAIL t2_req2 got=%b exp=100", ExpSrc); end
    checks++; if (cause !== 2'd2) begin failures++; $display("FAIL t2_cause2 got=%0d exp=2", cause); end
    has_exp = 1'b1;
    step(1);
    has_exp = 1'b0;
    is_eret = 1'b1;
    step(1);
    is_eret = 1'b0;
    step(1);
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL t2_drained got=%b exp=000", pending); end
  endtask

  task automatic test_block_mask;
    exp_block = 1'b1;
    irq_in = 3'b100;
    step(1);
    irq_in = 3'b000;
    step(6);
    checks++; if (pending !== 3'b100) begin failures++; $display("FAIL t3_pending got=%b exp=100", pending); end
    checks++; if (ExpSrc !== 3'b000) begin failures++; $display("FAIL t3_blocked got=%b exp=000", ExpSrc); end
    exp_block = 1'b0;
    step(2);
    checks++; if (ExpSrc !== 3'b100) begin failures++; $display("FAIL t3_unblocked got=%b exp=100", ExpSrc); end
    src_mask = 3'b100;
    step(1);
    checks++; if (ExpSrc !== 3'b000) begin failures++; $display("FAIL t3_withdraw got=%b exp=000", ExpSrc); end
    checks++; if (pending !== 3'b100) begin failures++; $display("FAIL t3_pending_kept got=%b exp=100", pending); end
    checks++; if (in_service !== 1'b0) begin failures++; $display("FAIL t3_not_service got=%b exp=0", in_service); end
    src_mask = 3'b000;
    step(1);
    checks++; if (ExpSrc !== 3'b100) begin failures++; $display("FAIL t3_rereq got=%b exp=100", ExpSrc); end
    has_exp = 1'b1;
    step(1);
    has_exp = 1'b0;
    is_eret = 1'b1;
    step(1);
    is_eret = 1'b0;
    step(1);
  endtask

  task automatic test_overrun;
    irq_in = 3'b001;
    step(1);
    irq_in = 3'b000;
    step(1);
    irq_in = 3'b001;
    step(1);
    irq_in = 3'b000;
    step(3);
    checks++; if (overrun !== 3'b001) begin failures++; $display("FAIL t4_overrun got=%b exp=001", overrun); end
    checks++; if (ExpSrc !== 3'b001) begin failures++; $display("FAIL t4_req got=%b exp=001", ExpSrc); end
    has_exp = 1'b1;
    step(1);
    has_exp = 1'b0;
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL t4_pending_clr got=%b exp=000", pending); end
    is_eret = 1'b1;
    step(1);
    is_eret = 1'b0;
    step(3);
    checks++; if (ExpSrc !== 3'b000) begin failures++; $display("FAIL t4_single_req got=%b exp=000", ExpSrc); end
    checks++; if (overrun !== 3'b001) begin failures++; $display("FAIL t4_overrun_sticky got=%b exp=001", overrun); end
  endtask

  task automatic test_set_clear_same_cycle;
    irq_in = 3'b010;
    step(1);
    irq_in = 3'b000;
    step(2);
    irq_in = 3'b010;
    step(1);
    irq_in = 3'b000;
    step(1);
    has_exp = 1'b1;
    step(1);
    has_exp = 1'b0;
    checks++; if (pending !== 3'b010) begin failures++; $display("FAIL tsc_set_wins got=%b exp=010", pending); end
    checks++; if (overrun !== 3'b001) begin failures++; $display("FAIL tsc_no_overrun got=%b exp=001", overrun); end
    checks++; if (in_service !== 1'b1) begin failures++; $display("FAIL tsc_service got=%b exp=1", in_service); end
    is_eret = 1'b1;
    step(1);
    is_eret = 1'b0;
    step(1);
    checks++; if (ExpSrc !== 3'b010) begin failures++; $display("FAIL tsc_rereq got=%b exp=010", ExpSrc); end
    has_exp = 1'b1;
    step(1);
    has_exp = 1'b0;
    is_eret = 1'b1;
    step(1);
    is_eret = 1'b0;
    step(1);
  endtask

  task automatic test_level;
    irq2 = 3'b001;
    step(4);
    checks++; if (ExpSrc2 !== 3'b001) begin failures++; $display("FAIL t5_req got=%b exp=001", ExpSrc2); end
    has_exp2 = 1'b1;
    step(1);
    has_exp2 = 1'b0;
    checks++; if (pending2 !== 3'b001) begin failures++; $display("FAIL t5_level_kept got=%b exp=001", pending2); end
    checks++; if (in_service2 !== 1'b1) begin failures++; $display("FAIL t5_service got=%b exp=1", in_service2); end
    is_eret2 = 1'b1;
    step(1);
    is_eret2 = 1'b0;
    step(1);
    checks++; if (ExpSrc2 !== 3'b001) begin failures++; $display("FAIL t5_rereq got=%b exp=001", ExpSrc2); end
    irq2 = 3'b000;
    step(5);
    checks++; if (ExpSrc2 !== 3'b000) begin failures++; $display("FAIL t5_withdraw got=%b exp=000", ExpSrc2); end
    checks++; if (in_service2 !== 1'b0) begin failures++; $display("FAIL t5_idle got=%b exp=0", in_service2); end
    checks++; if (pending2 !== 3'b000) begin failures++; $display("FAIL t5_pending_drop got=%b exp=000", pending2); end
  endtask

  task automatic test_clr_mid_req;
    irq_in = 3'b100;
    step(1);
    irq_in = 3'b000;
    step(3);
    checks++; if (ExpSrc !== 3'b100) begin failures++; $display("FAIL t6_req got=%b exp=100", ExpSrc); end
    #3 clr = 1'b1;
    #1;
    checks++; if (ExpSrc !== 3'b000) begin failures++; $display("FAIL t6_async_expsrc got=%b exp=000", ExpSrc); end
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL t6_async_pending got=%b exp=000", pending); end
    checks++; if (cause !== 2'd0) begin failures++; $display("FAIL t6_async_cause got=%0d exp=0", cause); end
    checks++; if (overrun !== 3'b000) begin failures++; $display("FAIL t6_async_overrun got=%b exp=000", overrun); end
    step(1);
    clr = 1'b0;
    step(5);
    checks++; if (ExpSrc !== 3'b000) begin failures++; $display("FAIL t6_no_req got=%b exp=000", ExpSrc); end
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL t6_no_pending got=%b exp=000", pending); end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_priority();
    test_block_mask();
    test_overrun();
    test_set_clear_same_cycle();
    test_level();
    test_clr_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
